// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM state encoding and instruction constants.
package core_pkg;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

   typedef enum logic [2:0] {
      START,
      FETCH,
      WAIT,
      DRAIN,
      HOLD
   } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_mux.sv
// Priority select of the redirect source (trap > branch > jump) with the
// target forced to word alignment.
module fetch_redirect_mux #(
   parameter int unsigned XLEN = 32
) (
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_vec_i,
   input  logic            br_taken_i,
   input  logic [XLEN-1:0] br_target_i,
   input  logic            jmp_i,
   input  logic [XLEN-1:0] jmp_target_i,
   output logic            redir_c,
   output logic [XLEN-1:0] target_c
);

   logic [XLEN-1:0] raw_target;

   always_comb begin
      redir_c    = trap_i | br_taken_i | jmp_i;
      raw_target = jmp_target_i;
      if (trap_i) begin
         raw_target = trap_vec_i;
      end else if (br_taken_i) begin
         raw_target = br_target_i;
      end
      target_c = {raw_target[XLEN-1:2], 2'b00};
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC register, issues single-outstanding imem
// requests and holds the fetched instruction for decode.
module fetch_ctrl
   import core_pkg::*;
#(
   parameter int unsigned FETCH_TIMEOUT = 64,
   parameter int unsigned XLEN          = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_i,
   output logic [XLEN-1:0] pc_next_o,
   output logic            pc_stall_o,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_instr_o,
   output logic [XLEN-1:0] if_pc_o,
   input  logic            id_ready_i,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_vec_i,
   input  logic            br_taken_i,
   input  logic [XLEN-1:0] br_target_i,
   input  logic            jmp_i,
   input  logic [XLEN-1:0] jmp_target_i,
   output logic            flush_o,
   output logic            bus_err_o
);

   localparam int unsigned     CNT_W    = $clog2(FETCH_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

   fetch_state_e     state;
   logic [CNT_W-1:0] tmo_cnt;
   logic             redir;
   logic [XLEN-1:0]  redir_target;
   logic             adv;
   logic             timeout;

   fetch_redirect_mux #(
      .XLEN (XLEN)
   ) u_redirect_mux (
      .trap_i       (trap_i),
      .trap_vec_i   (trap_vec_i),
      .br_taken_i   (br_taken_i),
      .br_target_i  (br_target_i),
      .jmp_i        (jmp_i),
      .jmp_target_i (jmp_target_i),
      .redir_c      (redir),
      .target_c     (redir_target)
   );

   // PC-register and imem-port controls are combinational so a redirect
   // takes effect in the cycle it is raised.
   assign adv         = (state == HOLD) & id_ready_i;
   assign timeout     = (tmo_cnt == CNT_LAST);
   assign flush_o     = redir;
   assign pc_stall_o  = !(redir | adv);
   assign pc_next_o   = redir ? redir_target : pc_i + XLEN'(INSTR_BYTES);
   assign imem_req_o  = (state == FETCH) & !redir;
   assign imem_addr_o = pc_i;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= START;
         tmo_cnt    <= '0;
         if_valid_o <= 1'b0;
         if_instr_o <= '0;
         if_pc_o    <= '0;
         bus_err_o  <= 1'b0;
      end else begin
         bus_err_o <= 1'b0;
         case (state)
            START: begin
               state <= FETCH;
            end

            // A redirect here suppresses the request; the PC loads the
            // target and the request goes out next cycle instead.
            FETCH: begin
               if (!redir) begin
                  state   <= WAIT;
                  tmo_cnt <= '0;
               end
            end

            WAIT: begin
               if (imem_rvalid_i) begin
                  tmo_cnt <= '0;
                  if (redir) begin
                     state <= FETCH;
                  end else begin
                     if_instr_o <= imem_rdata_i;
                     if_pc_o    <= pc_i;
                     if_valid_o <= 1'b1;
                     state      <= HOLD;
                  end
               end else if (redir) begin
                  tmo_cnt <= '0;
                  state   <= DRAIN;
               end else if (timeout) begin
                  tmo_cnt   <= '0;
                  bus_err_o <= 1'b1;
                  state     <= FETCH;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end

            // The stale response must land before a new request may issue.
            DRAIN: begin
               if (imem_rvalid_i) begin
                  tmo_cnt <= '0;
                  state   <= FETCH;
               end else if (timeout) begin
                  tmo_cnt   <= '0;
                  bus_err_o <= 1'b1;
                  state     <= FETCH;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end

            HOLD: begin
               if (redir | id_ready_i) begin
                  if_valid_o <= 1'b0;
                  state      <= FETCH;
               end
            end

            default: begin
               state <= START;
            end
         endcase
      end
   end

endmodule
